// File: rtl/prod_rettangoli_pkg.sv
// Shared constants for the rectangle-pair producer: bus widths, FSM state
// encodings and the pair-count clamp.
package prod_rettangoli_pkg;

  localparam int N_W = 5;
  localparam int S_W = 10;
  localparam int D_W = 4;
  localparam int P_W = 6;

  localparam logic [N_W-1:0] N_MAX = 5'd16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WRDY = 3'd1;
  localparam logic [2:0] S_PRES = 3'd2;
  localparam logic [2:0] S_WACK = 3'd3;
  localparam logic [2:0] S_WEND = 3'd4;

  // Requests beyond a full sequence of 16 pairs are saturated.
  function automatic logic [N_W-1:0] clamp_n(input logic [N_W-1:0] n_in);
    logic [N_W-1:0] n_out;
    if (n_in > N_MAX) begin
      n_out = N_MAX;
    end else begin
      n_out = n_in;
    end
    return n_out;
  endfunction

endpackage

// File: rtl/prod_rettangoli_coppia.sv
// Next rectangle pair generator: a rises and b falls by k, both wrapping
// modulo 16.
module rc_prossima_coppia
  import prod_rettangoli_pkg::*;
(
  input  logic [D_W-1:0] a0,
  input  logic [D_W-1:0] b0,
  input  logic [D_W-1:0] k,
  output logic [D_W-1:0] a,
  output logic [D_W-1:0] b
);

  // The 4-bit adder and subtractor wrap naturally.
  always_comb begin
    a = a0 + k;
    b = b0 - k;
  end

endmodule

// File: rtl/prod_rettangoli.sv
// Producer side of the dav_/rfd handshake: sends n rectangle pairs to the
// perimeter unit and accumulates the perimeters it returns.
module prod_rettangoli
  import prod_rettangoli_pkg::*;
(
  input  logic           clock,
  input  logic           reset_,
  input  logic           start,
  input  logic [D_W-1:0] a0,
  input  logic [D_W-1:0] b0,
  input  logic [N_W-1:0] n,
  output logic [D_W-1:0] a,
  output logic [D_W-1:0] b,
  output logic           dav_,
  input  logic           rfd,
  input  logic [P_W-1:0] p,
  output logic [S_W-1:0] sum,
  output logic           done
);

  logic [2:0]     state_r,  state_s;
  logic [D_W-1:0] a0_r,     a0_s;
  logic [D_W-1:0] b0_r,     b0_s;
  logic [N_W-1:0] n_r,      n_s;
  logic [N_W-1:0] count_r,  count_s;
  logic [D_W-1:0] a_r,      a_s;
  logic [D_W-1:0] b_r,      b_s;
  logic [S_W-1:0] sum_r,    sum_s;
  logic           dav_n_r,  dav_n_s;
  logic           done_r,   done_s;

  logic [N_W-1:0] count_inc_s;
  logic [N_W-1:0] n_clamp_s;
  logic [D_W-1:0] next_a_s;
  logic [D_W-1:0] next_b_s;
  logic [S_W-1:0] p_ext_s;

  assign count_inc_s = count_r + 5'd1;
  assign n_clamp_s   = clamp_n(n);
  assign p_ext_s     = {{(S_W-P_W){1'b0}}, p};

  // Pair index count_r+1 is the one loaded when the current handshake ends.
  rc_prossima_coppia u_coppia (
    .a0 (a0_r),
    .b0 (b0_r),
    .k  (count_inc_s[D_W-1:0]),
    .a  (next_a_s),
    .b  (next_b_s)
  );

  // Next-state and next-output decode of the handshake FSM.
  always_comb begin
    state_s = state_r;
    a0_s    = a0_r;
    b0_s    = b0_r;
    n_s     = n_r;
    count_s = count_r;
    a_s     = a_r;
    b_s     = b_r;
    sum_s   = sum_r;
    dav_n_s = dav_n_r;
    done_s  = done_r;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          a0_s    = a0;
          b0_s    = b0;
          n_s     = n_clamp_s;
          count_s = {N_W{1'b0}};
          sum_s   = {S_W{1'b0}};
          if (n_clamp_s == {N_W{1'b0}}) begin
            done_s  = 1'b1;
            state_s = S_IDLE;
          end else begin
            done_s  = 1'b0;
            a_s     = a0;
            b_s     = b0;
            state_s = S_WRDY;
          end
        end else begin
          state_s = S_IDLE;
        end
      end

      S_WRDY: begin
        if (rfd) begin
          state_s = S_PRES;
        end else begin
          state_s = S_WRDY;
        end
      end

      S_PRES: begin
        dav_n_s = 1'b0;
        state_s = S_WACK;
      end

      S_WACK: begin
        if (!rfd) begin
          dav_n_s = 1'b1;
          state_s = S_WEND;
        end else begin
          state_s = S_WACK;
        end
      end

      S_WEND: begin
        if (rfd) begin
          sum_s   = sum_r + p_ext_s;
          count_s = count_inc_s;
          if (count_inc_s == n_r) begin
            done_s  = 1'b1;
            state_s = S_IDLE;
          end else begin
            a_s     = next_a_s;
            b_s     = next_b_s;
            state_s = S_PRES;
          end
        end else begin
          state_s = S_WEND;
        end
      end

      default: begin
        dav_n_s = 1'b1;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_r <= S_IDLE;
      a0_r    <= {D_W{1'b0}};
      b0_r    <= {D_W{1'b0}};
      n_r     <= {N_W{1'b0}};
      count_r <= {N_W{1'b0}};
      a_r     <= {D_W{1'b0}};
      b_r     <= {D_W{1'b0}};
      sum_r   <= {S_W{1'b0}};
      dav_n_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      a0_r    <= a0_s;
      b0_r    <= b0_s;
      n_r     <= n_s;
      count_r <= count_s;
      a_r     <= a_s;
      b_r     <= b_s;
      sum_r   <= sum_s;
      dav_n_r <= dav_n_s;
      done_r  <= done_s;
    end
  end

  assign a    = a_r;
  assign b    = b_r;
  assign dav_ = dav_n_r;
  assign sum  = sum_r;
  assign done = done_r;

endmodule

// File: tb/tb_prod_rettangoli.sv
// Directed bench for prod_rettangoli against a behavioural perimeter consumer
// that returns p = 2*(a+b) and can stall its acknowledge.
module tb_prod_rettangoli;

  logic       clock;
  logic       reset_;
  logic       start;
  logic [3:0] a0, b0;
  logic [4:0] n;
  logic [3:0] a, b;
  logic       dav_;
  logic       rfd;
  logic [5:0] p;
  logic [9:0] sum;
  logic       done;

  int vectors;
  int miscompares;

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int falls;
  int stall_bad;
  int cons_stall;
  int cstate;
  int wait_cnt;
  logic [3:0] la, lb;

  prod_rettangoli dut (
    .clock  (clock),
    .reset_ (reset_),
    .start  (start),
    .a0     (a0),
    .b0     (b0),
    .n      (n),
    .a      (a),
    .b      (b),
    .dav_   (dav_),
    .rfd    (rfd),
    .p      (p),
    .sum    (sum),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Consumer model: latch on dav_ low, hold rfd high cons_stall clocks,
  // ack with rfd low, then return the perimeter and raise rfd.
  initial begin
    rfd = 1'b1; p = 6'd0; cstate = 0; wait_cnt = 0; falls = 0; stall_bad = 0;
    forever begin
      @(posedge clock); #1;
      if (!reset_) begin
        cstate = 0;
        rfd = 1'b1;
      end else begin
        case (cstate)
          0: if (dav_ === 1'b0) begin
               la = a; lb = b;
               qa.push_back(a); qb.push_back(b);
               falls++;
               wait_cnt = cons_stall;
               cstate = 1;
             end
          1: begin
               if (dav_ !== 1'b0 || a !== la || b !== lb) stall_bad++;
               if (wait_cnt > 0) wait_cnt--;
               else begin rfd = 1'b0; cstate = 2; end
             end
          2: if (dav_ === 1'b1) begin
               p = 6'((la + 6'd0 + lb) * 2);
               rfd = 1'b1;
               cstate = 0;
             end else if (a !== la || b !== lb) stall_bad++;
          default: cstate = 0;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input int k, input logic [3:0] ea, input logic [3:0] eb);
    logic [31:0] oa, ob;
    oa = (k < qa.size()) ? 32'(qa[k]) : 32'hFFFF_FFFF;
    ob = (k < qb.size()) ? 32'(qb[k]) : 32'hFFFF_FFFF;
    check($sformatf("pair%0d_a", k), oa, 32'(ea));
    check($sformatf("pair%0d_b", k), ob, 32'(eb));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_ = 1'b0;
    start  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic kick(input logic [3:0] ia, input logic [3:0] ib, input logic [4:0] in_n);
    @(negedge clock);
    a0 = ia; b0 = ib; n = in_n;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run(input logic [3:0] ia, input logic [3:0] ib, input logic [4:0] in_n, input int stall);
    int budget;
    qa.delete(); qb.delete();
    falls = 0; stall_bad = 0;
    cons_stall = stall;
    kick(ia, ib, in_n);
    budget = 2000;
    @(negedge clock);
    while (done !== 1'b1 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check("run_done", 32'(done), 32'd1);
    check("run_dav_idle", 32'(dav_), 32'd1);
  endtask

  initial begin
    int budget;
    vectors = 0; miscompares = 0;
    reset_ = 1'b0; start = 1'b0; a0 = 4'd0; b0 = 4'd0; n = 5'd0; cons_stall = 0;

    do_reset();
    check("rst_dav", 32'(dav_), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    check("rst_b", 32'(b), 32'd0);

    // Single pair (3,5): perimeter 16.
    run(4'd3, 4'd5, 5'd1, 0);
    check("n1_sum", 32'(sum), 32'd16);
    check("n1_falls", 32'(falls), 32'd1);
    check_pair(0, 4'd3, 4'd5);

    do_reset();
    run(4'd3, 4'd5, 5'd3, 0);
    check("n3_sum", 32'(sum), 32'd48);
    check("n3_falls", 32'(falls), 32'd3);
    check_pair(0, 4'd3, 4'd5);
    check_pair(1, 4'd4, 4'd4);
    check_pair(2, 4'd5, 4'd3);

    // a wraps 15->0 and b wraps 0->15.
    do_reset();
    run(4'd15, 4'd0, 5'd2, 0);
    check("wrap_sum", 32'(sum), 32'd60);
    check_pair(0, 4'd15, 4'd0);
    check_pair(1, 4'd0, 4'd15);

    // n=0 completes on the start clock with no handshake.
    do_reset();
    qa.delete(); qb.delete(); falls = 0;
    kick(4'd7, 4'd7, 5'd0);
    @(negedge clock);
    check("n0_done", 32'(done), 32'd1);
    check("n0_sum", 32'(sum), 32'd0);
    repeat (6) @(negedge clock);
    check("n0_falls", 32'(falls), 32'd0);
    check("n0_dav", 32'(dav_), 32'd1);

    // Stalled ack: pairs (2,7),(3,6), perimeter 18 each.
    do_reset();
    run(4'd2, 4'd7, 5'd2, 10);
    check("stall_sum", 32'(sum), 32'd36);
    check("stall_stable", 32'(stall_bad), 32'd0);
    check("stall_falls", 32'(falls), 32'd2);

    // Reset while waiting for the ack of the second pair.
    do_reset();
    qa.delete(); qb.delete(); falls = 0;
    cons_stall = 6;
    kick(4'd3, 4'd5, 5'd3);
    budget = 500;
    @(negedge clock);
    while (!(sum === 10'd16 && dav_ === 1'b0) && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check("mid_sum", 32'(sum), 32'd16);
    check("mid_dav", 32'(dav_), 32'd0);
    reset_ = 1'b0;
    #1;
    check("arst_dav", 32'(dav_), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_ = 1'b1;
    // Pair (1,3) has perimeter 8.
    run(4'd1, 4'd3, 5'd1, 0);
    check("post_rst_sum", 32'(sum), 32'd8);
    check_pair(0, 4'd1, 4'd3);

    // n=20 saturates to 16 pairs (k,-k): perimeters 0 then 15 x 32.
    do_reset();
    run(4'd0, 4'd0, 5'd20, 0);
    check("clamp_falls", 32'(falls), 32'd16);
    check("clamp_sum", 32'(sum), 32'd480);
    check_pair(15, 4'd15, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
